// File: rtl/tl_rr_arbiter_pkg.sv
// rtl/tl_rr_arbiter_pkg.sv - shared widths, queue count and FSM encoding for tl_rr_arbiter
package tl_rr_arbiter_pkg;

  localparam int DATA_W   = 10;
  localparam int CNT_W    = 5;
  localparam int UMBRAL_W = 3;
  localparam int NUM_Q    = 4;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  // Destination output index lives in the two MSBs of every word.
  function automatic logic [1:0] dest_of(input logic [DATA_W-1:0] word);
    return word[DATA_W-1 -: 2];
  endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// rtl/tl_rr_pick.sv - combinational 4-way rotating-priority picker
module tl_rr_pick
  import tl_rr_arbiter_pkg::*;
(
  input  logic [NUM_Q-1:0] eligible,
  input  logic [1:0]       ptr,
  output logic [NUM_Q-1:0] grant,
  output logic [1:0]       gidx,
  output logic             any
);

  logic [1:0] cand;

  // Scan ptr, ptr+1, ... (mod 4); the first eligible candidate wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    cand  = ptr;
    for (int k = 0; k < NUM_Q; k++) begin
      cand = ptr + 2'(k);
      if (!any && eligible[cand]) begin
        grant[cand] = 1'b1;
        gidx        = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_rr_arbiter.sv
// rtl/tl_rr_arbiter.sv - round-robin 4-in/4-out FIFO mover with init FSM and per-output counters
module tl_rr_arbiter
  import tl_rr_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMBRAL_W-1:0]     umbral_bajo,
  input  logic [UMBRAL_W-1:0]     umbral_alto,
  input  logic [NUM_Q-1:0]        in_empty,
  input  logic [NUM_Q*DATA_W-1:0] in_head,
  input  logic [NUM_Q-1:0]        out_afull,
  output logic [NUM_Q-1:0]        pop_in,
  output logic [NUM_Q-1:0]        push_out,
  output logic [DATA_W-1:0]       data_out,
  output logic [UMBRAL_W-1:0]     cfg_bajo,
  output logic [UMBRAL_W-1:0]     cfg_alto,
  input  logic                    req,
  input  logic [1:0]              idx,
  output logic [CNT_W-1:0]        contador,
  output logic                    valid,
  output logic                    idle,
  output logic [1:0]              state
);

  state_t             state_q, state_d;
  logic [1:0]         ptr;
  logic [NUM_Q-1:0]   eligible, grant;
  logic [1:0]         gidx;
  logic               any, do_pop;
  logic [DATA_W-1:0]  head_sel;
  logic [CNT_W-1:0]   cnt [NUM_Q];

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_Q; i++)
      eligible[i] = !in_empty[i] && !out_afull[dest_of(in_head[i*DATA_W +: DATA_W])];
  end

  tl_rr_pick u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .gidx     (gidx),
    .any      (any)
  );

  // Raising init stops new pops immediately; the word already in flight still lands.
  assign do_pop   = (state_q == ST_ACTIVE) && !init && any;
  assign pop_in   = do_pop ? grant : '0;
  assign head_sel = in_head[gidx*DATA_W +: DATA_W];
  assign idle     = (state_q == ST_IDLE);
  assign state    = state_q;

  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_RESET:  state_d = ST_INIT;
        ST_INIT:   state_d = ST_IDLE;
        ST_IDLE:   if (!(&in_empty)) state_d = ST_ACTIVE;
        ST_ACTIVE: if ((&in_empty) && !(|push_out)) state_d = ST_IDLE;
        default:   state_d = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RESET;
      ptr      <= '0;
      push_out <= '0;
      data_out <= '0;
      cfg_bajo <= '0;
      cfg_alto <= '0;
    end else begin
      state_q  <= state_d;
      push_out <= '0;
      if (do_pop) begin
        push_out[dest_of(head_sel)] <= 1'b1;
        data_out                    <= head_sel;
        ptr                         <= gidx + 2'd1;
      end
      if (state_q == ST_INIT) begin
        cfg_bajo <= umbral_bajo;
        cfg_alto <= umbral_alto;
      end
    end
  end

  // Read samples the counter before this cycle's increment lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < NUM_Q; d++) cnt[d] <= '0;
      contador <= '0;
      valid    <= 1'b0;
    end else begin
      for (int d = 0; d < NUM_Q; d++)
        if (push_out[d]) cnt[d] <= cnt[d] + CNT_W'(1);
      valid <= req;
      if (req) contador <= cnt[idx];
    end
  end

endmodule
